// File: rtl/uart_pkg.sv
// Shared definitions for the word UART receiver: FSM encodings and default timing constants.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_pkg;

   // Receiver FSM states. PARITY is only visited when UART_WORD_RX_PARITY_EN is defined.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } rx_state_t;

   localparam int DEF_CLK_DIV      = 434;  // 50 MHz / 115200
   localparam int DEF_TIMEOUT_BITS = 32;   // idle bit periods tolerated inside a word
   localparam int WORD_BYTES       = 4;    // bytes packed per output word
   localparam int BAUD_W           = 16;   // baud counter width

endpackage

// File: rtl/uart_word_rx_byte.sv
// Byte deserialiser: synchronises uart_rxd, detects start, samples 8 data bits (+ optional parity) and stop.
// Latency: byte_vld/byte_err are combinational pulses in the cycle the stop bit is sampled.
// Backpressure: none; the caller must consume byte_vld in the cycle it is asserted.
// Optional feature: UART_WORD_RX_PARITY_EN adds an even-parity bit between data and stop.
// Ports: clock, rst_n, uart_rxd in; byte_vld, byte_dat[7:0], byte_err, start_edge, busy out.
module uart_byte_rx
   import uart_pkg::*;
#(
   parameter int CLK_DIV = DEF_CLK_DIV
)
(
   input  logic       clock,
   input  logic       rst_n,
   input  logic       uart_rxd,
   output logic       byte_vld,
   output logic [7:0] byte_dat,
   output logic       byte_err,
   output logic       start_edge,
   output logic       busy
);

   localparam logic [BAUD_W-1:0] FULL_LAST = BAUD_W'(CLK_DIV - 1);
   localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLK_DIV / 2 - 1);

   logic              rxd_meta;
   logic              rxd_sync;
   logic              rxd_prev;
   rx_state_t         state;
   rx_state_t         state_nxt;
   logic [BAUD_W-1:0] baud_cnt;
   logic [2:0]        bit_idx;
   logic [7:0]        shreg;
   logic              tick;
   logic              stop_bad;
`ifdef UART_WORD_RX_PARITY_EN
   logic              par_bit;
`endif

   // Synchroniser and history FF reset high so the idle line never looks like a start edge.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         rxd_meta <= 1'b1;
         rxd_sync <= 1'b1;
         rxd_prev <= 1'b1;
      end else begin
         rxd_meta <= uart_rxd;
         rxd_sync <= rxd_meta;
         rxd_prev <= rxd_sync;
      end
   end

   // Sample point: half a bit after the start edge, then one full bit per subsequent sample.
   always_comb begin
      tick = 1'b0;
      case (state)
         ST_START:                     tick = (baud_cnt == HALF_LAST);
         ST_DATA, ST_PARITY, ST_STOP:  tick = (baud_cnt == FULL_LAST);
         default:                      tick = 1'b0;
      endcase
   end

`ifdef UART_WORD_RX_PARITY_EN
   assign stop_bad = ~rxd_sync | (^{shreg, par_bit});
`else
   assign stop_bad = ~rxd_sync;
`endif

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      byte_vld   = 1'b0;
      byte_err   = 1'b0;
      start_edge = 1'b0;
      case (state)
         ST_IDLE: begin
            // A held-low line keeps rxd_prev low, so a break cannot retrigger.
            start_edge = rxd_prev & ~rxd_sync;
            if (start_edge) state_nxt = ST_START;
         end
         ST_START: begin
            if (tick) state_nxt = rxd_sync ? ST_IDLE : ST_DATA;
         end
         ST_DATA: begin
`ifdef UART_WORD_RX_PARITY_EN
            if (tick && bit_idx == 3'd7) state_nxt = ST_PARITY;
`else
            if (tick && bit_idx == 3'd7) state_nxt = ST_STOP;
`endif
         end
`ifdef UART_WORD_RX_PARITY_EN
         ST_PARITY: begin
            if (tick) state_nxt = ST_STOP;
         end
`endif
         ST_STOP: begin
            if (tick) begin
               state_nxt = ST_IDLE;
               byte_vld  = ~stop_bad;
               byte_err  = stop_bad;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Baud counter restarts on every state entry and after every sample inside DATA.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         baud_cnt <= '0;
         bit_idx  <= 3'd0;
         shreg    <= 8'd0;
      end else begin
         if (state == ST_IDLE || state_nxt != state || tick) baud_cnt <= '0;
         else                                                  baud_cnt <= baud_cnt + BAUD_W'(1);

         if (state == ST_START) bit_idx <= 3'd0;
         else if (state == ST_DATA && tick) begin
            shreg[bit_idx] <= rxd_sync;
            bit_idx        <= bit_idx + 3'd1;
         end
      end
   end

`ifdef UART_WORD_RX_PARITY_EN
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n)                          par_bit <= 1'b0;
      else if (state == ST_PARITY && tick) par_bit <= rxd_sync;
   end
`endif

   assign byte_dat = shreg;
   assign busy     = (state != ST_IDLE);

endmodule

// File: rtl/uart_word_rx.sv
// Packs four UART bytes (first byte in [31:24]) into a word presented on a valid/ready interface.
// Latency: word_valid rises the cycle after the 4th stop-bit sample.
// Backpressure: one-word output register; a word completing while it is held and not accepted is dropped (overrun).
// Optional feature: UART_WORD_RX_PARITY_EN (even parity per byte, handled in uart_byte_rx).
// Ports: clock, rst_n, uart_rxd, word_ready in; word_valid, word_data[31:0], frame_err, overrun, timeout, busy out.
module uart_word_rx
   import uart_pkg::*;
#(
   parameter int CLK_DIV      = DEF_CLK_DIV,
   parameter int TIMEOUT_BITS = DEF_TIMEOUT_BITS
)
(
   input  logic        clock,
   input  logic        rst_n,
   input  logic        uart_rxd,
   output logic        word_valid,
   input  logic        word_ready,
   output logic [31:0] word_data,
   output logic        frame_err,
   output logic        overrun,
   output logic        timeout,
   output logic        busy
);

   localparam logic [23:0] TMO_LIMIT = 24'(TIMEOUT_BITS * CLK_DIV);

   logic        byte_vld;
   logic [7:0]  byte_dat;
   logic        byte_err;
   logic        start_edge;
   logic [1:0]  byte_cnt;
   logic [23:0] acc;
   logic [23:0] tmo_cnt;
   logic        word_done;
   logic        tmo_fire;

   uart_byte_rx #(
      .CLK_DIV (CLK_DIV)
   ) u_byte_rx (
      .clock      (clock),
      .rst_n      (rst_n),
      .uart_rxd   (uart_rxd),
      .byte_vld   (byte_vld),
      .byte_dat   (byte_dat),
      .byte_err   (byte_err),
      .start_edge (start_edge),
      .busy       (busy)
   );

   assign word_done = byte_vld && (byte_cnt == 2'(WORD_BYTES - 1));

   // Timeout only fires while idle between bytes of a partial word; a start edge in
   // the same cycle wins, so it can never coincide with frame_err or overrun.
   assign tmo_fire = !busy && !start_edge && (byte_cnt != 2'd0) && (tmo_cnt == TMO_LIMIT - 24'd1);

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         byte_cnt   <= 2'd0;
         acc        <= 24'd0;
         tmo_cnt    <= 24'd0;
         word_valid <= 1'b0;
         word_data  <= 32'd0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         frame_err <= byte_err;
         timeout   <= tmo_fire;
         overrun   <= 1'b0;

         // A bad frame or a stale partial word resets assembly to a word boundary.
         if (byte_err || tmo_fire) begin
            byte_cnt <= 2'd0;
            acc      <= 24'd0;
         end else if (byte_vld) begin
            acc      <= {acc[15:0], byte_dat};
            byte_cnt <= byte_cnt + 2'd1;
         end

         if (start_edge || byte_cnt == 2'd0 || tmo_fire) tmo_cnt <= 24'd0;
         else if (!busy)                                  tmo_cnt <= tmo_cnt + 24'd1;

         // Accept-and-reload in one cycle is allowed; otherwise a held word is never overwritten.
         if (word_done) begin
            if (!word_valid || word_ready) begin
               word_data  <= {acc, byte_dat};
               word_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (word_valid && word_ready) begin
            word_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_word_rx.sv
// Self-checking bench for uart_word_rx with CLK_DIV=8, TIMEOUT_BITS=4.
// Latency: stop bit of a frame started after posedge c0 is sampled at posedge c0+STOP_LAT.
// Backpressure: word_ready is driven per scenario.
module tb_uart_word_rx;

   localparam int CLK_DIV      = 8;
   localparam int TIMEOUT_BITS = 4;
`ifdef UART_WORD_RX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   // 2 sync FFs + history FF, half-bit wait, then one bit period per remaining frame bit.
   localparam int STOP_LAT = 3 + CLK_DIV / 2 + (NBITS - 1) * CLK_DIV;

   logic        clock      = 1'b0;
   logic        rst_n      = 1'b0;
   logic        uart_rxd   = 1'b1;
   logic        word_ready = 1'b1;
   logic        word_valid;
   logic [31:0] word_data;
   logic        frame_err;
   logic        overrun;
   logic        timeout;
   logic        busy;

   typedef struct {
      logic [31:0] data;
      int          cyc;
   } wrec_t;

   wrec_t exp_q[$];
   wrec_t got_q[$];

   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc   = 0;
   int          ferr_seen, ovr_seen, tmo_seen, hold_viol;
   int          rise_cyc = 0;
   logic        wv_q = 1'b0;
   logic [31:0] wd_q = 32'd0;

   uart_word_rx #(
      .CLK_DIV      (CLK_DIV),
      .TIMEOUT_BITS (TIMEOUT_BITS)
   ) dut (
      .clock      (clock),
      .rst_n      (rst_n),
      .uart_rxd   (uart_rxd),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .word_data  (word_data),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .timeout    (timeout),
      .busy       (busy)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // Monitor: records accepted words with the cycle word_valid rose, counts error pulses
   // and any change of word_data while word_valid is held.
   always @(negedge clock) begin
      if (rst_n) begin
         if (word_valid && !wv_q) rise_cyc = cyc;
         if (word_valid && wv_q && word_data !== wd_q) hold_viol++;
         if (word_valid && word_ready) got_q.push_back('{word_data, rise_cyc});
         ferr_seen += int'(frame_err);
         ovr_seen  += int'(overrun);
         tmo_seen  += int'(timeout);
         wv_q = word_valid;
         wd_q = word_data;
      end else begin
         wv_q = 1'b0;
      end
   end

   task automatic clear_sb();
      exp_q.delete();
      got_q.delete();
      ferr_seen = 0;
      ovr_seen  = 0;
      tmo_seen  = 0;
      hold_viol = 0;
   endtask

   // Call at #1 after a posedge; returns at #1 after the posedge ending the frame.
   task automatic send_byte(input logic [7:0] b, input bit stop_ok, input bit par_ok, output int c0);
      logic [10:0] frame;
`ifdef UART_WORD_RX_PARITY_EN
      frame = {stop_ok, (^b) ^ ~par_ok, b, 1'b0};
`else
      frame = {(^b) ^ ~par_ok, stop_ok, b, 1'b0};
`endif
      c0 = cyc;
      for (int i = 0; i < NBITS; i++) begin
         uart_rxd = frame[i];
         repeat (CLK_DIV) @(posedge clock);
         #1;
      end
      uart_rxd = 1'b1;
   endtask

   task automatic send_word(input logic [31:0] w, input bit push, output int c_last);
      for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], 1'b1, 1'b1, c_last);
      if (push) exp_q.push_back('{w, c_last + STOP_LAT});
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      uart_rxd = 1'b1;
      word_ready = 1'b1;
      idle(3);
      n_cmp++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL reset_word_valid got %0b want 0", word_valid); end
      n_cmp++; if (word_data !== 32'd0) begin n_err++; $display("FAIL reset_word_data got %h want 0", word_data); end
      n_cmp++; if (frame_err !== 1'b0)  begin n_err++; $display("FAIL reset_frame_err got %0b want 0", frame_err); end
      n_cmp++; if (overrun !== 1'b0)    begin n_err++; $display("FAIL reset_overrun got %0b want 0", overrun); end
      n_cmp++; if (timeout !== 1'b0)    begin n_err++; $display("FAIL reset_timeout got %0b want 0", timeout); end
      n_cmp++; if (busy !== 1'b0)       begin n_err++; $display("FAIL reset_busy got %0b want 0", busy); end
      rst_n = 1'b1;
      idle(4);
   endtask

   task automatic test_back_to_back();
      int c;
      wrec_t g, e;
      clear_sb();
      word_ready = 1'b1;
      send_word(32'hDEADBEEF, 1'b1, c);
      idle(20);
      n_cmp++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL b2b_count got %0d want %0d", got_q.size(), exp_q.size()); end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front(); e = exp_q.pop_front();
         n_cmp++; if (g.data !== e.data) begin n_err++; $display("FAIL b2b_data got %h want %h", g.data, e.data); end
         n_cmp++; if (g.cyc != e.cyc)    begin n_err++; $display("FAIL b2b_latency got cycle %0d want %0d", g.cyc, e.cyc); end
      end
      n_cmp++; if (ferr_seen + ovr_seen + tmo_seen != 0) begin n_err++; $display("FAIL b2b_errors got %0d pulses want 0", ferr_seen + ovr_seen + tmo_seen); end
   endtask

   task automatic test_timeout();
      int c;
      wrec_t g, e;
      clear_sb();
      word_ready = 1'b1;
      send_byte(8'h12, 1'b1, 1'b1, c);
      send_byte(8'h34, 1'b1, 1'b1, c);
      idle(40 * CLK_DIV);
      send_word(32'h56789ABC, 1'b1, c);
      idle(20);
      n_cmp++; if (tmo_seen != 1)  begin n_err++; $display("FAIL tmo_pulses got %0d want 1", tmo_seen); end
      n_cmp++; if (ferr_seen != 0) begin n_err++; $display("FAIL tmo_frame_err got %0d want 0", ferr_seen); end
      n_cmp++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL tmo_count got %0d want %0d", got_q.size(), exp_q.size()); end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front(); e = exp_q.pop_front();
         n_cmp++; if (g.data !== e.data) begin n_err++; $display("FAIL tmo_data got %h want %h", g.data, e.data); end
         n_cmp++; if (g.cyc != e.cyc)    begin n_err++; $display("FAIL tmo_latency got cycle %0d want %0d", g.cyc, e.cyc); end
      end
   endtask

   task automatic test_frame_err();
      int c;
      wrec_t g, e;
      clear_sb();
      word_ready = 1'b1;
      send_byte(8'hA1, 1'b1, 1'b1, c);
      send_byte(8'hA2, 1'b1, 1'b1, c);
      send_byte(8'hA3, 1'b0, 1'b1, c);
      idle(2 * CLK_DIV);
      send_word(32'h01020304, 1'b1, c);
      idle(20);
      n_cmp++; if (ferr_seen != 1) begin n_err++; $display("FAIL ferr_pulses got %0d want 1", ferr_seen); end
      n_cmp++; if (tmo_seen + ovr_seen != 0) begin n_err++; $display("FAIL ferr_other got %0d want 0", tmo_seen + ovr_seen); end
      n_cmp++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL ferr_count got %0d want %0d", got_q.size(), exp_q.size()); end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front(); e = exp_q.pop_front();
         n_cmp++; if (g.data !== e.data) begin n_err++; $display("FAIL ferr_data got %h want %h", g.data, e.data); end
         n_cmp++; if (g.cyc != e.cyc)    begin n_err++; $display("FAIL ferr_latency got cycle %0d want %0d", g.cyc, e.cyc); end
      end
   endtask

   task automatic test_overrun();
      int c1, c2;
      wrec_t g, e;
      clear_sb();
      word_ready = 1'b0;
      send_word(32'h11111111, 1'b0, c1);
      exp_q.push_back('{32'h11111111, c1 + STOP_LAT});
      send_word(32'h22222222, 1'b0, c2);
      idle(10);
      n_cmp++; if (ovr_seen != 1)              begin n_err++; $display("FAIL ovr_pulses got %0d want 1", ovr_seen); end
      n_cmp++; if (word_valid !== 1'b1)        begin n_err++; $display("FAIL ovr_valid_held got %0b want 1", word_valid); end
      n_cmp++; if (word_data !== 32'h11111111) begin n_err++; $display("FAIL ovr_data_held got %h want 11111111", word_data); end
      n_cmp++; if (hold_viol != 0)             begin n_err++; $display("FAIL ovr_data_stable got %0d changes want 0", hold_viol); end
      word_ready = 1'b1;
      @(negedge clock);
      n_cmp++; if (word_valid !== 1'b1) begin n_err++; $display("FAIL ovr_valid_before_accept got %0b want 1", word_valid); end
      @(negedge clock);
      n_cmp++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL ovr_valid_drop got %0b want 0", word_valid); end
      n_cmp++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL ovr_count got %0d want %0d", got_q.size(), exp_q.size()); end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front(); e = exp_q.pop_front();
         n_cmp++; if (g.data !== e.data) begin n_err++; $display("FAIL ovr_data got %h want %h", g.data, e.data); end
         n_cmp++; if (g.cyc != e.cyc)    begin n_err++; $display("FAIL ovr_latency got cycle %0d want %0d", g.cyc, e.cyc); end
      end
      idle(2);
   endtask

   task automatic test_glitch_reset();
      int c;
      wrec_t g, e;
      clear_sb();
      word_ready = 1'b0;
      @(posedge clock); #1;
      uart_rxd = 1'b0;
      idle(2);
      uart_rxd = 1'b1;
      idle(2);
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL glitch_busy got %0b want 1", busy); end
      idle(3 * CLK_DIV);
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL glitch_idle got %0b want 0", busy); end
      // A glitch counted as a byte would misalign this word.
      send_word(32'hCAFEBABE, 1'b0, c);
      idle(10);
      n_cmp++; if (word_valid !== 1'b1 || word_data !== 32'hCAFEBABE) begin n_err++; $display("FAIL glitch_word got v=%0b %h want v=1 cafebabe", word_valid, word_data); end
      n_cmp++; if (ferr_seen + tmo_seen + ovr_seen != 0) begin n_err++; $display("FAIL glitch_errors got %0d want 0", ferr_seen + tmo_seen + ovr_seen); end
      // Start a frame and abort it with reset in the middle of the data bits.
      uart_rxd = 1'b0;
      idle(3 * CLK_DIV);
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_data_busy got %0b want 1", busy); end
      rst_n = 1'b0;
      #1;
      n_cmp++; if (word_valid !== 1'b0 || word_data !== 32'd0) begin n_err++; $display("FAIL rst_word got v=%0b %h want v=0 0", word_valid, word_data); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %0b want 0", busy); end
      n_cmp++; if ({frame_err, overrun, timeout} !== 3'b000) begin n_err++; $display("FAIL rst_pulses got %b want 000", {frame_err, overrun, timeout}); end
      uart_rxd = 1'b1;
      idle(3);
      rst_n = 1'b1;
      word_ready = 1'b1;
      idle(4);
      send_word(32'h0BADF00D, 1'b1, c);
      idle(20);
      n_cmp++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL rst_recover_count got %0d want %0d", got_q.size(), exp_q.size()); end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front(); e = exp_q.pop_front();
         n_cmp++; if (g.data !== e.data) begin n_err++; $display("FAIL rst_recover_data got %h want %h", g.data, e.data); end
         n_cmp++; if (g.cyc != e.cyc)    begin n_err++; $display("FAIL rst_recover_latency got cycle %0d want %0d", g.cyc, e.cyc); end
      end
   endtask

`ifdef UART_WORD_RX_PARITY_EN
   task automatic test_parity();
      int c;
      wrec_t g, e;
      clear_sb();
      word_ready = 1'b1;
      send_byte(8'h11, 1'b1, 1'b1, c);
      send_byte(8'h22, 1'b1, 1'b1, c);
      send_byte(8'h03, 1'b1, 1'b0, c);
      idle(2 * CLK_DIV);
      send_word(32'h03030303, 1'b1, c);
      idle(20);
      n_cmp++; if (ferr_seen != 1) begin n_err++; $display("FAIL par_pulses got %0d want 1", ferr_seen); end
      n_cmp++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL par_count got %0d want %0d", got_q.size(), exp_q.size()); end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front(); e = exp_q.pop_front();
         n_cmp++; if (g.data !== e.data) begin n_err++; $display("FAIL par_data got %h want %h", g.data, e.data); end
         n_cmp++; if (g.cyc != e.cyc)    begin n_err++; $display("FAIL par_latency got cycle %0d want %0d", g.cyc, e.cyc); end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_back_to_back();
      test_timeout();
      test_frame_err();
      test_overrun();
      test_glitch_reset();
`ifdef UART_WORD_RX_PARITY_EN
      test_parity();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/uart_word_rx.md
Name: uart_word_rx

Overview:
- Receive-side counterpart of the team's 32-bit word UART transmitter.
- Deserialises 8N1 UART frames and packs 4 consecutive bytes into one 32-bit word. The first byte received goes to bits [31:24]; each byte arrives LSB first.
- Presents the word on a valid/ready interface to the NPU command/data path.
- A timeout between bytes discards a partial word so the receiver resynchronises to word boundaries.

Parameters:
- CLK_DIV, 434, clock cycles per UART bit (50 MHz / 115200); legal range 4..65535.
- TIMEOUT_BITS, 32, idle bit periods allowed between bytes of one word before a partial word is dropped.

Ports:
- clock  in  1  system clock.
- rst_n  in  1  reset; one clock, asynchronous assert, active-low.
- uart_rxd  in  1  asynchronous serial line; idles high.
- word_valid  out  1  assembled word available.
- word_ready  in  1  consumer accepts the word when word_valid && word_ready.
- word_data  out  32  assembled word; stable while word_valid=1.
- frame_err  out  1  one-cycle pulse on a bad stop bit (or bad parity when the option is enabled).
- overrun  out  1  one-cycle pulse when a completed word is lost because the output register is full.
- timeout  out  1  one-cycle pulse when a partial word is dropped.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values: word_valid=0, word_data=0, frame_err=0, overrun=0, timeout=0, busy=0; FSM in IDLE; byte_cnt=0.
- Reset asserted mid-frame or mid-word aborts immediately; nothing is output.
- Input path:
  - uart_rxd passes through a 2-FF synchroniser plus one history FF.
  - A start is detected on a synchronised falling edge (prev=1, cur=0) while in IDLE.
  - A line held low (break) never re-triggers until it returns high.
- Baud counter: 16-bit; cleared on each state entry.
- FSM IDLE:
  - On start edge, go to START.
- FSM START:
  - Wait CLK_DIV/2 (integer divide) cycles, then sample.
  - If the sample is 1 (glitch), return to IDLE with no error.
  - Otherwise go to DATA with bit index 0.
- FSM DATA:
  - Every CLK_DIV cycles, sample into shift register bit [index], LSB first.
  - After bit 7, go to STOP.
- FSM STOP:
  - Wait CLK_DIV cycles, then sample.
  - If the sample is 1: the byte is good. Shift it into the word accumulator ({acc[23:0], byte}), increment byte_cnt, go to IDLE.
  - If the sample is 0: pulse frame_err, clear byte_cnt and the accumulator, go to IDLE.
- Word completion:
  - When the 4th good byte is accepted (byte_cnt wraps 3->0), the word is complete.
  - On the next clock, word_data is loaded with the word and word_valid=1.
  - Latency: one cycle after the stop-bit sample.
- Handshake:
  - word_valid stays high until word_valid && word_ready; word_valid drops the following cycle.
  - word_data must not change while word_valid=1.
- Simultaneous completion and accept: if a word completes in the same cycle word_valid && word_ready is true, the new word is loaded, word_valid stays 1, and there is no overrun.
- Overrun: if a word completes while word_valid=1 and word_ready=0, pulse overrun and discard the new word; the held word is unchanged.
- Timeout:
  - A 24-bit counter runs in IDLE while byte_cnt!=0 and is cleared on any start edge.
  - When it reaches TIMEOUT_BITS*CLK_DIV, pulse timeout and clear byte_cnt and the accumulator.
  - The timeout counter does not run when byte_cnt=0.
- Error precedence: frame_err, timeout and overrun are mutually exclusive in any one cycle by construction.

Optional Feature:
- Macro: UART_WORD_RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP, sampled one CLK_DIV after bit 7.
  - Even parity is required (XOR of the 8 data bits and the parity bit = 0).
  - On mismatch: pulse frame_err at the stop sample, drop the byte and the partial word.
- Undefined: plain 8N1; no PARITY state or parity logic is synthesised.

Decomposition:
- Shared package/include uart_pkg:
  - FSM state encodings IDLE/START/DATA/PARITY/STOP.
  - Default CLK_DIV and TIMEOUT_BITS constants.
  - Byte count of a word (4).
  - Baud counter width (16).
- One natural sub-module: uart_byte_rx.
  - Contains the synchroniser, FSM, baud counter and optional parity.
  - Outputs a byte-valid pulse, the byte, and a frame-error pulse.
  - The top level keeps word assembly, the timeout, the output register and the handshake.

Test Plan (CLK_DIV=8, TIMEOUT_BITS=4):
- Send bytes 0xDE,0xAD,0xBE,0xEF back-to-back with word_ready=1 -> one word_valid pulse; word_data=0xDEADBEEF exactly 1 cycle after the 4th stop sample; no error pulses.
- Send 0x12,0x34, idle 40 bit times, then 0x56,0x78,0x9A,0xBC -> timeout pulses once; the only word delivered is 0x56789ABC.
- 3rd byte sent with stop bit=0 -> frame_err pulses once; no word; the next 4 clean bytes 0x01,0x02,0x03,0x04 yield 0x01020304.
- Hold word_ready=0; send 0x11111111 then 0x22222222 -> overrun pulses at the 2nd completion; word_data stays 0x11111111. Raising word_ready drops word_valid on the next cycle.
- 2-cycle low glitch on the idle line -> returns to IDLE from START; busy returns to 0; no error pulses and no byte counted. Then assert rst_n=0 mid-DATA of a subsequent frame -> all outputs return to reset values immediately.
- With UART_WORD_RX_PARITY_EN: byte 0x03 with parity bit 1 -> frame_err pulse and the word is dropped; with parity 0 -> accepted.
